// File: rtl/alu_vector_checker.sv
// alu_vector_checker
//
// Hardware vector engine for the 32-bit ALU. It reads packed vectors from a
// synchronous-read memory and drives each vector's operands and function into
// the ALU. It compares the ALU result and zero flag with the vector's expected
// values and reports pass/fail, an error count and the index of the first
// mismatch.
//
// Ports
//   clk_i              clock, rising edge
//   reset_ni           asynchronous active-low reset
//   start_i            run request, sampled only in idle
//   vec_rd_o           vector memory read enable (high only in fetch)
//   vec_addr_o         vector index (holds the current index)
//   vec_data_i         read data, valid the cycle after vec_rd_o:
//                      {a[103:72], b[71:40], f[39:36], exp_y[35:4], exp_z[3:0]}
//   alu_a_o/alu_b_o    registered ALU operands
//   alu_f_o            registered ALU function (f[2:0]; f[3] is ignored)
//   alu_y_i/alu_z_i    ALU result and zero flag
//   busy_o             high while vectors are being processed
//   done_o             one-cycle pulse at the end of a run
//   pass_o             last run had no mismatches (valid from done)
//   err_count_o        mismatching vectors this run, saturates at 255
//   first_err_valid_o  at least one mismatch this run
//   first_err_idx_o    index of the first mismatch (0 while not valid)

module alu_vector_checker #(
    parameter int unsigned NUM_VECTORS = 21,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned SETTLE      = 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              start_i,
    output logic              vec_rd_o,
    output logic [ADDR_W-1:0] vec_addr_o,
    input  logic [103:0]      vec_data_i,
    output logic [31:0]       alu_a_o,
    output logic [31:0]       alu_b_o,
    output logic [2:0]        alu_f_o,
    input  logic [31:0]       alu_y_i,
    input  logic              alu_z_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [7:0]        err_count_o,
    output logic              first_err_valid_o,
    output logic [ADDR_W-1:0] first_err_idx_o
);

    localparam int unsigned       CntW       = $clog2(SETTLE + 1);
    localparam logic [CntW-1:0]   SettleInit = CntW'(SETTLE);
    localparam logic [ADDR_W-1:0] LastIdx    = ADDR_W'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StSettle,
        StCheck,
        StDone
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [CntW-1:0]   cnt_q;
    logic [31:0]       exp_y_q;
    logic [3:0]        exp_z_q;
    logic              vec_rd_q;
    logic [31:0]       alu_a_q;
    logic [31:0]       alu_b_q;
    logic [2:0]        alu_f_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic [7:0]        err_count_q;
    logic [7:0]        err_count_d;
    logic              first_err_valid_q;
    logic [ADDR_W-1:0] first_err_idx_q;

    logic mismatch;
    logic unused_f3;

    // f[3] carries no meaning for the 3-bit ALU.
    assign unused_f3 = vec_data_i[39];

    // A nonzero exp_z[3:1] can never match the 1-bit zero flag.
    assign mismatch = (alu_y_i != exp_y_q) || (exp_z_q != {3'b000, alu_z_i});

    always_comb begin
        err_count_d = err_count_q;
        if (mismatch && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q           <= StIdle;
            idx_q             <= '0;
            cnt_q             <= '0;
            exp_y_q           <= '0;
            exp_z_q           <= '0;
            vec_rd_q          <= 1'b0;
            alu_a_q           <= '0;
            alu_b_q           <= '0;
            alu_f_q           <= '0;
            busy_q            <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
        end else begin
            // Single-cycle strobes default low.
            done_q   <= 1'b0;
            vec_rd_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        err_count_q       <= '0;
                        first_err_valid_q <= 1'b0;
                        first_err_idx_q   <= '0;
                        pass_q            <= 1'b0;
                        idx_q             <= '0;
                        busy_q            <= 1'b1;
                        vec_rd_q          <= 1'b1;
                        state_q           <= StFetch;
                    end
                end
                StFetch: begin
                    state_q <= StLoad;
                end
                StLoad: begin
                    alu_a_q <= vec_data_i[103:72];
                    alu_b_q <= vec_data_i[71:40];
                    alu_f_q <= vec_data_i[38:36];
                    exp_y_q <= vec_data_i[35:4];
                    exp_z_q <= vec_data_i[3:0];
                    cnt_q   <= SettleInit;
                    state_q <= StSettle;
                end
                StSettle: begin
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    err_count_q <= err_count_d;
                    if (mismatch && !first_err_valid_q) begin
                        first_err_valid_q <= 1'b1;
                        first_err_idx_q   <= idx_q;
                    end
                    if (idx_q == LastIdx) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_d == 8'd0);
                        state_q <= StDone;
                    end else begin
                        idx_q    <= idx_q + 1'b1;
                        vec_rd_q <= 1'b1;
                        state_q  <= StFetch;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign vec_rd_o          = vec_rd_q;
    assign vec_addr_o        = idx_q;
    assign alu_a_o           = alu_a_q;
    assign alu_b_o           = alu_b_q;
    assign alu_f_o           = alu_f_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign err_count_o       = err_count_q;
    assign first_err_valid_o = first_err_valid_q;
    assign first_err_idx_o   = first_err_idx_q;

endmodule

// File: tb/tb_alu_vector_checker.sv
// Self-checking bench for alu_vector_checker. Provides a vector memory and a
// behavioural ALU, runs table-driven error scenarios, randomized runs checked
// against a reference model, and hand-written start-while-busy and mid-run
// reset sequences.

module tb_alu_vector_checker;

    localparam int unsigned NV = 21;
    localparam int unsigned AW = 5;
    localparam int unsigned ST = 1;
    localparam int unsigned VecCycles = 3 + ST;
    localparam int unsigned RunCycles = NV * VecCycles;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          start = 1'b0;
    logic          vec_rd;
    logic [AW-1:0] vec_addr;
    logic [103:0]  vec_data = '0;
    logic [31:0]   alu_a, alu_b, alu_y;
    logic [2:0]    alu_f;
    logic          alu_z;
    logic          busy, done, pass, first_err_valid;
    logic [7:0]    err_count;
    logic [AW-1:0] first_err_idx;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
        logic [31:0] y;
        logic [3:0]  z;
    } vec_t;

    vec_t          vecs[NV];
    logic [103:0]  mem[32];
    int unsigned   addr_log[$];

    always #5 clk = ~clk;

    alu_vector_checker #(
        .NUM_VECTORS(NV),
        .ADDR_W     (AW),
        .SETTLE     (ST)
    ) dut (
        .clk_i            (clk),
        .reset_ni         (reset_n),
        .start_i          (start),
        .vec_rd_o         (vec_rd),
        .vec_addr_o       (vec_addr),
        .vec_data_i       (vec_data),
        .alu_a_o          (alu_a),
        .alu_b_o          (alu_b),
        .alu_f_o          (alu_f),
        .alu_y_i          (alu_y),
        .alu_z_i          (alu_z),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .err_count_o      (err_count),
        .first_err_valid_o(first_err_valid),
        .first_err_idx_o  (first_err_idx)
    );

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
        case (f)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return a & ~b;
            3'd5:    return a | ~b;
            3'd6:    return a - b;
            default: return {31'd0, $signed(a) < $signed(b)};
        endcase
    endfunction

    // Synchronous-read vector memory and combinational ALU.
    always @(posedge clk) begin
        if (vec_rd) begin
            vec_data <= mem[vec_addr];
            addr_log.push_back(int'(vec_addr));
        end
    end

    assign alu_y = alu_ref(alu_a, alu_b, alu_f);
    assign alu_z = (alu_y == 32'd0);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic build_clean();
        for (int i = 0; i < NV; i++) begin
            vecs[i].a = $urandom;
            vecs[i].b = (i % 4 == 0) ? vecs[i].a : $urandom;
            vecs[i].f = 4'($urandom_range(0, 15));
        end
        // Vector 0: OR giving a nonzero result; vector 3: ADD giving 4.
        vecs[0].a = 32'd5; vecs[0].b = 32'd0; vecs[0].f = 4'h9;
        vecs[3].a = 32'd1; vecs[3].b = 32'd3; vecs[3].f = 4'h2;
        for (int i = 0; i < NV; i++) begin
            vecs[i].y = alu_ref(vecs[i].a, vecs[i].b, vecs[i].f[2:0]);
            vecs[i].z = {3'b000, vecs[i].y == 32'd0};
        end
    endtask

    // kind 0: exp_y off by one, 1: zero flag inverted, 2: exp_z upper bit set
    task automatic corrupt(input int idx, input int kind);
        if (idx < 0) return;
        case (kind)
            0:       vecs[idx].y = vecs[idx].y + 32'd1;
            1:       vecs[idx].z = vecs[idx].z ^ 4'h1;
            default: vecs[idx].z = vecs[idx].z | 4'h2;
        endcase
    endtask

    task automatic load_mem();
        for (int i = 0; i < 32; i++) mem[i] = '0;
        for (int i = 0; i < NV; i++) begin
            mem[i] = {vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].y, vecs[i].z};
        end
    endtask

    // Reference: evaluate each vector on the ALU model and compare with its
    // expected fields.
    task automatic model(output int err, output int fi, output bit ok);
        logic [31:0] y;
        bit          mis;
        err = 0;
        fi  = 0;
        for (int i = 0; i < NV; i++) begin
            y   = alu_ref(vecs[i].a, vecs[i].b, vecs[i].f[2:0]);
            mis = (vecs[i].y != y) || (vecs[i].z != {3'b000, y == 32'd0});
            if (mis) begin
                if (err == 0) fi = i;
                if (err < 255) err++;
            end
        end
        ok = (err == 0);
    endtask

    task automatic run(input string tag, input int p1, input int p2, input int exp_err,
                       input int exp_fi, input bit exp_pass);
        int c;
        int extra_done;
        bit seq_ok;
        addr_log.delete();
        @(negedge clk);
        start = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
            start = (c == p1) || (c == p2);
            if (c == 1) chk({tag, "_busy_rise"}, 64'(busy), 64'd1);
        end while (!done && c < 300);
        start = 1'b0;
        chk({tag, "_done_cycle"}, 64'(c), 64'(RunCycles + 1));
        chk({tag, "_err_count"}, 64'(err_count), 64'(exp_err));
        chk({tag, "_first_valid"}, 64'(first_err_valid), 64'(exp_err != 0));
        chk({tag, "_first_idx"}, 64'(first_err_idx), 64'(exp_fi));
        chk({tag, "_pass"}, 64'(pass), 64'(exp_pass));
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        chk({tag, "_last_alu"}, {29'd0, alu_f, alu_a ^ alu_b},
            {29'd0, vecs[NV-1].f[2:0], vecs[NV-1].a ^ vecs[NV-1].b});
        extra_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        chk({tag, "_no_rerun"}, 64'(extra_done), 64'd0);
        chk({tag, "_hold"}, {54'd0, pass, err_count, first_err_valid},
            {54'd0, exp_pass, 8'(exp_err), exp_err != 0});
        seq_ok = (addr_log.size() == NV);
        for (int i = 0; i < addr_log.size() && i < NV; i++) begin
            if (addr_log[i] != i) seq_ok = 1'b0;
        end
        chk({tag, "_addr_seq"}, 64'(seq_ok), 64'd1);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_zero_ops"}, {alu_a, alu_b}, 64'd0);
        chk({tag, "_zero_ctl"},
            64'({vec_rd, vec_addr, alu_f, busy, done, pass, err_count, first_err_valid,
                 first_err_idx}), 64'd0);
    endtask

    typedef struct {
        int e0, e1, e2;
        int k0, k1, k2;
        int exp_err;
        int exp_fi;
        bit exp_pass;
    } scen_t;

    initial begin
        scen_t tbl[5];
        int    err, fi, n;
        bit    ok;

        tbl[0] = '{-1, -1, -1, 0, 0, 0, 0, 0, 1'b1};  // all pass
        tbl[1] = '{ 3, -1, -1, 0, 0, 0, 1, 3, 1'b0};  // single y error
        tbl[2] = '{ 0,  1, -1, 1, 2, 0, 2, 0, 1'b0};  // zero flag, exp_z width
        tbl[3] = '{ 7, 12, 20, 0, 1, 2, 3, 7, 1'b0};  // multiple errors
        tbl[4] = '{-1, -1, -1, 0, 0, 0, 0, 0, 1'b1};  // clean follow-up

        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int s = 0; s < 5; s++) begin
            build_clean();
            corrupt(tbl[s].e0, tbl[s].k0);
            corrupt(tbl[s].e1, tbl[s].k1);
            corrupt(tbl[s].e2, tbl[s].k2);
            load_mem();
            run($sformatf("tbl%0d", s), 0, 0, tbl[s].exp_err, tbl[s].exp_fi, tbl[s].exp_pass);
        end

        for (int r = 0; r < 6; r++) begin
            build_clean();
            n = $urandom_range(0, 4);
            for (int j = 0; j < n; j++) corrupt($urandom_range(0, NV - 1), $urandom_range(0, 2));
            load_mem();
            model(err, fi, ok);
            run($sformatf("rnd%0d", r), 0, 0, err, fi, ok);
        end

        // Start pulses in the first fetch and in the check of vector 10.
        build_clean();
        corrupt(9, 0);
        load_mem();
        run("busy_start", 1, VecCycles * 11, 1, 9, 1'b0);

        // Reset during the settle of vector 5, then a full clean run.
        build_clean();
        load_mem();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (VecCycles * 5 + 2) @(negedge clk);
        chk("pre_reset_busy", 64'(busy), 64'd1);
        reset_n = 1'b0;
        #1;
        chk_zero("midrun_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_zero("post_reset");
        run("after_reset", 0, 0, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
